// File: rtl/mult_div_unit_pkg.sv
// Types and constants for the multiply/divide unit, built on the shared instruction defines.
`include "instr_defs.sv"

package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = `MUDI_MULT,
        OP_MULTU = `MUDI_MULTU,
        OP_DIV   = `MUDI_DIV,
        OP_DIVU  = `MUDI_DIVU,
        OP_MTHI  = `MUDI_MTHI,
        OP_MTLO  = `MUDI_MTLO,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } mudiOp_e;

    localparam int COUNT_W = 4;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_defs.sv
// Shared instruction-definition constants for the decoder and the multiply/divide unit.
// Holds the mudiOp encodings and the default HI/LO operation latencies.
`ifndef INSTR_DEFS_SV
`define INSTR_DEFS_SV

`define MUDI_MULT   3'b000
`define MUDI_MULTU  3'b001
`define MUDI_DIV    3'b010
`define MUDI_DIVU   3'b011
`define MUDI_MTHI   3'b100
`define MUDI_MTLO   3'b101

`define MULT_CYCLES 5
`define DIV_CYCLES  10

`endif

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers and
// fixed-latency busy modelling for the hazard logic.
`include "instr_defs.sv"

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = `MULT_CYCLES,
    parameter int DIV_CYCLES  = `DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mudiOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        sel,
    output logic        busy,
    output logic [31:0] out
);

    localparam logic [COUNT_W-1:0] MULT_LOAD = COUNT_W'(MULT_CYCLES);
    localparam logic [COUNT_W-1:0] DIV_LOAD  = COUNT_W'(DIV_CYCLES);

    logic [31:0]        hiReg, loReg;
    logic [31:0]        pendHiReg, pendLoReg;
    logic               pendWrReg;
    logic [COUNT_W-1:0] countReg;

    logic [63:0] mulSigned, mulUnsigned;
    logic [31:0] divSignedQ, divSignedR, divUnsignedQ, divUnsignedR;
    logic [31:0] divisorS, divisorU;
    logic        divOverflow, divByZero;
    mudiOp_e     opCode;

    assign opCode = mudiOp_e'(mudiOp);

    always_comb begin
        mulSigned   = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
        mulUnsigned = {32'd0, srcA} * {32'd0, srcB};

        // Substituting 1 for a zero or overflowing divisor keeps the operators well defined;
        // the overflow case then yields exactly INT_MIN rem 0, and zero-divide is never committed.
        divByZero   = (srcB == 32'd0);
        divOverflow = (srcA == INT_MIN) && (srcB == NEG_ONE);
        divisorS    = (divByZero || divOverflow) ? 32'd1 : srcB;
        divisorU    = divByZero ? 32'd1 : srcB;

        divSignedQ   = $signed(srcA) / $signed(divisorS);
        divSignedR   = $signed(srcA) % $signed(divisorS);
        divUnsignedQ = srcA / divisorU;
        divUnsignedR = srcA % divisorU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hiReg     <= '0;
            loReg     <= '0;
            pendHiReg <= '0;
            pendLoReg <= '0;
            pendWrReg <= 1'b0;
            countReg  <= '0;
        end else if (countReg != '0) begin
            // In flight: any new start is ignored until the count drains.
            countReg <= countReg - 1'b1;
            if (countReg == COUNT_W'(1) && pendWrReg) begin
                hiReg <= pendHiReg;
                loReg <= pendLoReg;
            end
        end else if (start) begin
            case (opCode)
                OP_MULT: begin
                    {pendHiReg, pendLoReg} <= mulSigned;
                    pendWrReg <= 1'b1;
                    countReg  <= MULT_LOAD;
                end
                OP_MULTU: begin
                    {pendHiReg, pendLoReg} <= mulUnsigned;
                    pendWrReg <= 1'b1;
                    countReg  <= MULT_LOAD;
                end
                OP_DIV: begin
                    pendLoReg <= divSignedQ;
                    pendHiReg <= divSignedR;
                    pendWrReg <= !divByZero;
                    countReg  <= DIV_LOAD;
                end
                OP_DIVU: begin
                    pendLoReg <= divUnsignedQ;
                    pendHiReg <= divUnsignedR;
                    pendWrReg <= !divByZero;
                    countReg  <= DIV_LOAD;
                end
                OP_MTHI: hiReg <= srcA;
                OP_MTLO: loReg <= srcA;
                default: ;
            endcase
        end
    end

    assign busy = (countReg != '0);
    assign out  = sel ? hiReg : loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, HI/LO results,
// divide-by-zero, overflow, start-while-busy and mid-operation reset.
`timescale 1ns/1ps

module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mudiOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        sel;
    logic        busy;
    logic [31:0] out;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mudiOp (mudiOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .sel    (sel),
        .busy   (busy),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
        sel = 1'b1; #1; hi = out;
        sel = 1'b0; #1; lo = out;
    endtask

    // Issues one command and returns how many cycles busy stayed high afterwards.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        start = 1'b1; mudiOp = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic opAndCheck(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input int expCycles, input logic [31:0] expHi,
                              input logic [31:0] expLo);
        int cyc;
        logic [31:0] hi, lo;
        runOp(op, a, b, cyc);
        checkVal({tag, " busy cycles"}, 32'(cyc), 32'(expCycles));
        readHiLo(hi, lo);
        checkVal({tag, " HI"}, hi, expHi);
        checkVal({tag, " LO"}, lo, expLo);
    endtask

    initial begin
        int cyc;
        logic [31:0] hi, lo;

        reset = 1'b1; start = 1'b0; mudiOp = 3'b000; srcA = '0; srcB = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkVal("reset busy", 32'(busy), 32'd0);
        readHiLo(hi, lo);
        checkVal("reset HI", hi, 32'd0);
        checkVal("reset LO", lo, 32'd0);
        @(negedge clk);

        opAndCheck("mult -2*3", MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        opAndCheck("multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
                   32'hFFFF_FFFE, 32'h0000_0001);
        opAndCheck("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        runOp(MTHI, 32'h0000_1234, 32'd0, cyc);
        checkVal("mthi busy cycles", 32'(cyc), 32'd0);
        sel = 1'b1; #1;
        checkVal("mthi HI", out, 32'h0000_1234);
        runOp(MTLO, 32'h0000_5678, 32'd0, cyc);
        checkVal("mtlo busy cycles", 32'(cyc), 32'd0);
        sel = 1'b0; #1;
        checkVal("mtlo LO", out, 32'h0000_5678);

        opAndCheck("divu /0", DIVU, 32'd99, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);
        opAndCheck("div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
                   32'h0000_0000, 32'h8000_0000);
        opAndCheck("divu 100/7", DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Start while busy: the divu in busy cycle 2 must be ignored.
        start = 1'b1; mudiOp = MULT; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk);
        start = 1'b0;
        cyc = busy ? 1 : 0;
        @(negedge clk);
        if (busy) cyc++;
        start = 1'b1; mudiOp = DIVU; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        checkVal("busy-start cycles", 32'(cyc), 32'd5);
        readHiLo(hi, lo);
        checkVal("busy-start HI", hi, 32'd0);
        checkVal("busy-start LO", lo, 32'd12);

        // Reset in busy cycle 4 of a divide: result is discarded.
        start = 1'b1; mudiOp = DIV; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("mid-reset busy before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("mid-reset busy", 32'(busy), 32'd0);
        readHiLo(hi, lo);
        checkVal("mid-reset HI", hi, 32'd0);
        checkVal("mid-reset LO", lo, 32'd0);
        repeat (12) @(negedge clk);
        checkVal("post-reset busy", 32'(busy), 32'd0);
        readHiLo(hi, lo);
        checkVal("post-reset HI", hi, 32'd0);
        checkVal("post-reset LO", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
